// File: rtl/sorted_insert_writer_pkg.sv
// Shared constants and state encoding for the 32x8 search memory: used by the
// insert writer, the search control and the top-level memory mux.
package sorted_insert_writer_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCmp,
        StPlace,
        StDone
    } writer_state_e;

endpackage

// File: rtl/sorted_insert_writer.sv
// Insertion-sort writer: adds one byte per Start into the single-port memory,
// shifting larger entries up by one so words 0..Count-1 stay ascending.
module sorted_insert_writer
    import sorted_insert_writer_pkg::*;
(
    input  logic          Clock,
    input  logic          aReset,
    input  logic          Start,
    input  logic          Clear,
    input  logic [DW-1:0] Data,
    input  logic [DW-1:0] mem_out,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] DataIn,
    output logic          Write,
    output logic [AW:0]   Count,
    output logic          Busy,
    output logic          Done,
    output logic          Full,
    output logic          Reject
);

    writer_state_e r_state, w_state_d;
    logic [DW-1:0] r_key, w_key_d;
    logic [AW:0]   r_idx, w_idx_d;
    logic [AW:0]   r_count, w_count_d;
    logic          r_reject, w_reject_d;
    logic [AW:0]   w_idx_m1;
    logic          w_full;

    assign w_idx_m1 = r_idx - (AW+1)'(1);
    assign w_full   = (r_count == (AW+1)'(DEPTH));

    always_ff @(posedge Clock or negedge aReset) begin
        if (!aReset) begin
            r_state  <= StIdle;
            r_key    <= '0;
            r_idx    <= '0;
            r_count  <= '0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_key    <= w_key_d;
            r_idx    <= w_idx_d;
            r_count  <= w_count_d;
            r_reject <= w_reject_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_key_d    = r_key;
        w_idx_d    = r_idx;
        w_count_d  = r_count;
        w_reject_d = 1'b0;
        Address    = '0;
        DataIn     = '0;
        Write      = 1'b0;
        Done       = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (Clear) begin
                    w_count_d = '0;
                end else if (Start) begin
                    if (w_full) begin
                        w_reject_d = 1'b1;
                    end else begin
                        w_key_d   = Data;
                        w_idx_d   = r_count;
                        w_state_d = (r_count != '0) ? StRead : StPlace;
                    end
                end
            end
            StRead: begin
                Address   = w_idx_m1[AW-1:0];
                w_state_d = StCmp;
            end
            StCmp: begin
                // Strict compare keeps duplicates stable: a new equal lands after old ones.
                if (mem_out > r_key) begin
                    Address   = r_idx[AW-1:0];
                    DataIn    = mem_out;
                    Write     = 1'b1;
                    w_idx_d   = w_idx_m1;
                    w_state_d = (w_idx_m1 == '0) ? StPlace : StRead;
                end else begin
                    w_state_d = StPlace;
                end
            end
            StPlace: begin
                Address   = r_idx[AW-1:0];
                DataIn    = r_key;
                Write     = 1'b1;
                w_state_d = StDone;
            end
            StDone: begin
                Done      = 1'b1;
                w_count_d = r_count + (AW+1)'(1);
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign Count  = r_count;
    assign Busy   = (r_state != StIdle);
    assign Full   = w_full;
    assign Reject = r_reject;

endmodule

// File: tb/tb_sorted_insert_writer.sv
// Directed bench for sorted_insert_writer with a behavioural 32x8 memory that
// has a registered read port.
module tb_sorted_insert_writer;

    logic       Clock;
    logic       aReset;
    logic       Start;
    logic       Clear;
    logic [7:0] Data;
    logic [7:0] mem_out;
    logic [4:0] Address;
    logic [7:0] DataIn;
    logic       Write;
    logic [5:0] Count;
    logic       Busy;
    logic       Done;
    logic       Full;
    logic       Reject;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [32];
    logic [4:0] wa [$];
    logic [7:0] wd [$];

    sorted_insert_writer dut (
        .Clock   (Clock),
        .aReset  (aReset),
        .Start   (Start),
        .Clear   (Clear),
        .Data    (Data),
        .mem_out (mem_out),
        .Address (Address),
        .DataIn  (DataIn),
        .Write   (Write),
        .Count   (Count),
        .Busy    (Busy),
        .Done    (Done),
        .Full    (Full),
        .Reject  (Reject)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (Write) mem[Address] <= DataIn;
        mem_out <= mem[Address];
    end

    task automatic do_insert(input logic [7:0] v, output int done_cyc);
        wa.delete();
        wd.delete();
        done_cyc = -1;
        @(negedge Clock);
        Start = 1'b1;
        Data  = v;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        Data  = 8'hA5;
        for (int k = 1; k <= 80; k++) begin
            @(negedge Clock);
            if (Write) begin
                wa.push_back(Address);
                wd.push_back(DataIn);
            end
            if (Done) begin
                done_cyc = k;
                break;
            end
        end
        n_tests++;
        if (done_cyc < 0) begin
            n_fail++;
            $display("FAIL done_timeout: key=%h got no Done, required Done within 80 cycles", v);
        end
    endtask

    task automatic do_clear();
        @(negedge Clock);
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        Clear = 1'b0;
        @(negedge Clock);
        n_tests++;
        if (Count !== 6'd0) begin
            n_fail++;
            $display("FAIL clear_count: got %0d, required 0", Count);
        end
    endtask

    task automatic test_reset();
        aReset = 1'b0;
        repeat (2) @(negedge Clock);
        n_tests++;
        if ({Address, DataIn, Write, Busy, Done, Reject} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h din=%h wr=%b busy=%b done=%b rej=%b, required all 0",
                     Address, DataIn, Write, Busy, Done, Reject);
        end
        n_tests++;
        if (Count !== 6'd0 || Full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_count: got count=%0d full=%b, required 0/0", Count, Full);
        end
        aReset = 1'b1;
    endtask

    task automatic test_first_insert();
        int dc;
        do_insert(8'h40, dc);
        n_tests++;
        if (dc !== 2) begin
            n_fail++;
            $display("FAIL first_latency: got cycle %0d, required 2", dc);
        end
        n_tests++;
        if (wa.size() !== 1 || wa[0] !== 5'd0 || wd[0] !== 8'h40) begin
            n_fail++;
            $display("FAIL first_write: got %0d writes first addr=%h data=%h, required 1 write addr=00 data=40",
                     wa.size(), wa[0], wd[0]);
        end
        @(negedge Clock);
        n_tests++;
        if (Count !== 6'd1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL first_count: got count=%0d busy=%b, required 1/0", Count, Busy);
        end
    endtask

    task automatic build_list();
        int dc;
        do_clear();
        do_insert(8'h10, dc);
        do_insert(8'h30, dc);
        n_tests++;
        if (dc !== 4) begin
            n_fail++;
            $display("FAIL append30_latency: got cycle %0d, required 4", dc);
        end
        do_insert(8'h20, dc);
        n_tests++;
        if (dc !== 6) begin
            n_fail++;
            $display("FAIL mid20_latency: got cycle %0d, required 6", dc);
        end
        n_tests++;
        if (wa.size() !== 2 || wa[0] !== 5'd2 || wd[0] !== 8'h30 || wa[1] !== 5'd1 || wd[1] !== 8'h20) begin
            n_fail++;
            $display("FAIL mid20_writes: got %0d writes (%h:%h, %h:%h), required (02:30, 01:20)",
                     wa.size(), wa[0], wd[0], wa[1], wd[1]);
        end
    endtask

    task automatic test_sorted();
        build_list();
        n_tests++;
        if (mem[0] !== 8'h10 || mem[1] !== 8'h20 || mem[2] !== 8'h30) begin
            n_fail++;
            $display("FAIL sorted_mem: got %h %h %h, required 10 20 30", mem[0], mem[1], mem[2]);
        end
    endtask

    task automatic test_append();
        int dc;
        do_insert(8'h50, dc);
        n_tests++;
        if (dc !== 4 || wa.size() !== 1 || wa[0] !== 5'd3 || wd[0] !== 8'h50) begin
            n_fail++;
            $display("FAIL append50: got cycle %0d, %0d writes addr=%h data=%h, required 4, 1 write 03:50",
                     dc, wa.size(), wa[0], wd[0]);
        end
        @(negedge Clock);
        n_tests++;
        if (Count !== 6'd4) begin
            n_fail++;
            $display("FAIL append_count: got %0d, required 4", Count);
        end
    endtask

    task automatic test_front_and_dup();
        int dc;
        build_list();
        do_insert(8'h05, dc);
        n_tests++;
        if (dc !== 8) begin
            n_fail++;
            $display("FAIL front_latency: got cycle %0d, required 8", dc);
        end
        n_tests++;
        if (wa.size() !== 4 || wa[0] !== 5'd3 || wa[1] !== 5'd2 || wa[2] !== 5'd1 || wa[3] !== 5'd0 ||
            wd[0] !== 8'h30 || wd[1] !== 8'h20 || wd[2] !== 8'h10 || wd[3] !== 8'h05) begin
            n_fail++;
            $display("FAIL front_writes: got %0d writes, last addr=%h data=%h, required 03:30 02:20 01:10 00:05",
                     wa.size(), wa[wa.size()-1], wd[wd.size()-1]);
        end
        // Duplicate 0x20 must land after the existing 0x20 (addr3), shifting only 0x30.
        do_insert(8'h20, dc);
        n_tests++;
        if (dc !== 6 || wa.size() !== 2 || wa[0] !== 5'd4 || wd[0] !== 8'h30 || wa[1] !== 5'd3 ||
            wd[1] !== 8'h20) begin
            n_fail++;
            $display("FAIL dup_stable: got cycle %0d, %0d writes (%h:%h, %h:%h), required 6, (04:30, 03:20)",
                     dc, wa.size(), wa[0], wd[0], wa[1], wd[1]);
        end
    endtask

    task automatic test_full_reject();
        int dc;
        logic saw_write;
        do_clear();
        for (int i = 0; i < 32; i++) do_insert(8'(i * 4 + 1), dc);
        @(negedge Clock);
        n_tests++;
        if (Count !== 6'd32 || Full !== 1'b1 || mem[31] !== 8'd125) begin
            n_fail++;
            $display("FAIL fill: got count=%0d full=%b mem31=%h, required 32/1/7d", Count, Full, mem[31]);
        end
        Start = 1'b1;
        Data  = 8'h99;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        @(negedge Clock);
        saw_write = Write;
        n_tests++;
        if (Reject !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_pulse: got reject=%b busy=%b, required 1/0", Reject, Busy);
        end
        @(negedge Clock);
        saw_write = saw_write | Write;
        n_tests++;
        if (Reject !== 1'b0 || saw_write !== 1'b0 || Count !== 6'd32) begin
            n_fail++;
            $display("FAIL reject_after: got reject=%b write=%b count=%0d, required 0/0/32",
                     Reject, saw_write, Count);
        end
        do_clear();
        n_tests++;
        if (Full !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_full: got %b, required 0", Full);
        end
    endtask

    task automatic test_reset_mid();
        int dc;
        build_list();
        @(negedge Clock);
        Start = 1'b1;
        Data  = 8'h05;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (2) @(negedge Clock);
        n_tests++;
        if (Write !== 1'b1 || Address !== 5'd3) begin
            n_fail++;
            $display("FAIL mid_cmp_shift: got write=%b addr=%h, required 1/03", Write, Address);
        end
        aReset = 1'b0;
        #1;
        n_tests++;
        if ({Address, DataIn, Write, Busy, Done, Reject} !== 17'd0 || Count !== 6'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got addr=%h din=%h wr=%b busy=%b done=%b rej=%b count=%0d, required all 0",
                     Address, DataIn, Write, Busy, Done, Reject, Count);
        end
        @(negedge Clock);
        aReset = 1'b1;
        do_insert(8'h77, dc);
        n_tests++;
        if (dc !== 2 || wa.size() !== 1 || wa[0] !== 5'd0 || wd[0] !== 8'h77) begin
            n_fail++;
            $display("FAIL post_reset_insert: got cycle %0d, %0d writes addr=%h data=%h, required 2, 00:77",
                     dc, wa.size(), wa[0], wd[0]);
        end
        @(negedge Clock);
        n_tests++;
        if (Count !== 6'd1) begin
            n_fail++;
            $display("FAIL post_reset_count: got %0d, required 1", Count);
        end
    endtask

    initial begin
        Start  = 1'b0;
        Clear  = 1'b0;
        Data   = 8'h00;
        aReset = 1'b0;
        test_reset();
        test_first_insert();
        test_sorted();
        test_append();
        test_front_and_dup();
        test_full_reject();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
